writeback_queue: RTL and testbench



---
 rtl/writeback_queue_pkg.sv | 12 +
 rtl/writeback_queue_wb_fifo.sv | 58 +++++
 rtl/writeback_queue.sv | 144 ++++++++++++++
 tb/tb_writeback_queue.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_queue_pkg.sv
// rtl/writeback_queue_pkg.sv - shared types and constants for the writeback queue
package writeback_queue_pkg;

  localparam int WB_XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]         rt;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_queue_wb_fifo.sv
// rtl/writeback_queue_wb_fifo.sv - in-order write queue with dual push, single pop and a read-all view
module wb_fifo
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push0,
  input  wb_entry_t       i_push0_entry,
  input  logic            i_push1,
  input  wb_entry_t       i_push1_entry,
  input  logic            i_pop,
  output wb_entry_t       o_head_entry,
  output logic [CW-1:0]   o_count,
  output logic [PW-1:0]   o_head,
  output wb_entry_t       o_mem [DEPTH]
);

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            w_pop;
  logic [CW-1:0]   w_n_push;

  assign w_pop    = i_pop && (r_count != '0);
  assign w_n_push = CW'(i_push0) + CW'(i_push1);

  // Storage is not reset; validity comes from head/count only.
  always_ff @(posedge clk) begin
    if (i_push0) r_mem[r_tail] <= i_push0_entry;
    if (i_push1) r_mem[r_tail + PW'(1)] <= i_push1_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + PW'(w_n_push);
      r_head  <= r_head + PW'(w_pop);
      r_count <= r_count + w_n_push - CW'(w_pop);
    end
  end

  assign o_head_entry = r_mem[r_head];
  assign o_count      = r_count;
  assign o_head       = r_head;
  assign o_mem        = r_mem;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) r_count <= CW'(DEPTH));
  a_push_order:  assert property (@(posedge clk) disable iff (rst) i_push1 |-> i_push0);

endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - dual-lane writeback retire queue with forwarding; optional WB_RETIRE_COUNT_EN
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = WB_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            interlock,
  input  logic [31:0]     pc,
  input  logic [63:0]     inst,
  input  logic [4:0]      u_rt,
  input  logic            u_rt_flag,
  input  logic            u_half,
  input  logic [63:0]     mem_doutb,
  input  logic [XLEN-1:0] l_tdata,
  input  logic [4:0]      l_rt,
  input  logic            l_rt_flag,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            wb_stall,
  input  logic [4:0]      fwd_addr,
  output logic            fwd_hit,
  output logic [XLEN-1:0] fwd_data
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [63:0]     retired
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic            w_accept;
  logic            w_u_lane;
  logic            w_l_lane;
  logic            w_u_valid;
  logic            w_l_valid;
  wb_entry_t       w_u_entry;
  wb_entry_t       w_l_entry;
  logic            w_push0;
  logic            w_push1;
  wb_entry_t       w_push0_entry;
  logic            w_pop;
  wb_entry_t       w_head_entry;
  logic [CW-1:0]   w_count;
  logic [PW-1:0]   w_head;
  wb_entry_t       w_mem [DEPTH];
  logic [CW-1:0]   w_next_count;
  logic [PW-1:0]   w_idx;
  logic            r_pop_valid;
  wb_entry_t       r_pop_entry;
  logic            w_unused;

  assign w_unused = ^{pc, inst};

  assign w_accept  = !interlock;
  assign w_u_lane  = u_rt_flag && (u_rt != REG_ZERO);
  assign w_l_lane  = l_rt_flag && (l_rt != REG_ZERO);
  assign w_l_valid = w_accept && w_l_lane;
  // The lower lane is younger, so a same-destination upper write is dead.
  assign w_u_valid = w_accept && w_u_lane && !(w_l_valid && (l_rt == u_rt));

  assign w_u_entry = '{rt: u_rt, data: (u_half ? mem_doutb[63:32] : mem_doutb[31:0])};
  assign w_l_entry = '{rt: l_rt, data: l_tdata};

  assign w_push0       = w_u_valid || w_l_valid;
  assign w_push0_entry = w_u_valid ? w_u_entry : w_l_entry;
  assign w_push1       = w_u_valid && w_l_valid;
  assign w_pop         = (w_count != '0);
  assign w_next_count  = w_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push0       (w_push0),
    .i_push0_entry (w_push0_entry),
    .i_push1       (w_push1),
    .i_push1_entry (w_l_entry),
    .i_pop         (w_pop),
    .o_head_entry  (w_head_entry),
    .o_count       (w_count),
    .o_head        (w_head),
    .o_mem         (w_mem)
  );

  // Popped entry is staged one cycle before it reaches the register-file port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pop_valid <= 1'b0;
      r_pop_entry <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      wb_stall    <= 1'b0;
    end else begin
      r_pop_valid <= w_pop;
      if (w_pop) r_pop_entry <= w_head_entry;
      rf_we <= r_pop_valid;
      if (r_pop_valid) begin
        rf_waddr <= r_pop_entry.rt;
        rf_wdata <= r_pop_entry.data;
      end
      wb_stall <= (w_next_count > CW'(DEPTH - 2));
    end
  end

  // Oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    w_idx    = '0;
    if (fwd_addr != REG_ZERO) begin
      if (rf_we && (rf_waddr == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = rf_wdata;
      end
      if (r_pop_valid && (r_pop_entry.rt == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_pop_entry.data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        w_idx = w_head + PW'(i);
        if ((CW'(i) < w_count) && (w_mem[w_idx].rt == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = w_mem[w_idx].data;
        end
      end
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if (w_accept) begin
      retired <= retired + 64'(w_u_lane) + 64'(w_l_lane);
    end
  end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - scoreboard bench for writeback_queue
module tb_writeback_queue;

  logic        clk;
  logic        rst;
  logic        interlock;
  logic        r_tie;
  logic        r_il_drv;
  logic [31:0] pc;
  logic [63:0] inst;
  logic [4:0]  u_rt;
  logic        u_rt_flag;
  logic        u_half;
  logic [63:0] mem_doutb;
  logic [31:0] l_tdata;
  logic [4:0]  l_rt;
  logic        l_rt_flag;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_stall;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] retired;
`endif

  logic [36:0] sbq[$];
  int n_pass;
  int n_total;

  assign interlock = r_tie ? wb_stall : r_il_drv;

  writeback_queue dut (
    .clk       (clk),
    .rst       (rst),
    .interlock (interlock),
    .pc        (pc),
    .inst      (inst),
    .u_rt      (u_rt),
    .u_rt_flag (u_rt_flag),
    .u_half    (u_half),
    .mem_doutb (mem_doutb),
    .l_tdata   (l_tdata),
    .l_rt      (l_rt),
    .l_rt_flag (l_rt_flag),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .wb_stall  (wb_stall),
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`ifdef WB_RETIRE_COUNT_EN
    ,
    .retired   (retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    u_rt_flag = 1'b0;
    l_rt_flag = 1'b0;
  endtask

  task automatic drive(input logic uf, input logic [4:0] urt, input logic uh, input logic [63:0] md,
                       input logic lf, input logic [4:0] lrt, input logic [31:0] ld);
    u_rt_flag = uf;
    u_rt      = urt;
    u_half    = uh;
    mem_doutb = md;
    l_rt_flag = lf;
    l_rt      = lrt;
    l_tdata   = ld;
    pc        = pc + 32'd8;
    inst      = {32'h0000_0013, pc};
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    sbq.push_back({a, d});
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got r%0d=%0h expected no write", rf_waddr, rf_wdata);
      end else begin
        logic [36:0] e;
        e = sbq.pop_front();
        chk("wb_addr", 64'(rf_waddr), 64'(e[36:32]));
        chk("wb_data", 64'(rf_wdata), 64'(e[31:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    n_pass = 0; n_total = 0;
    rst = 1'b1; r_tie = 1'b0; r_il_drv = 1'b0;
    pc = '0; inst = '0; u_rt = '0; u_half = 1'b0; mem_doutb = '0;
    l_tdata = '0; l_rt = '0; fwd_addr = '0;
    idle();
    step(); step();
    chk("rst_we", 64'(rf_we), 0);
    chk("rst_waddr", 64'(rf_waddr), 0);
    chk("rst_wdata", 64'(rf_wdata), 0);
    chk("rst_stall", 64'(wb_stall), 0);
`ifdef WB_RETIRE_COUNT_EN
    chk("rst_retired", retired, 0);
`endif
    rst = 1'b0;
    step();

    // Lone lower write: rf_we after the second edge following acceptance.
    drive(0, 0, 0, 0, 1, 5'd5, 32'h1234);
    expect_wr(5, 32'h1234);
    step();
    idle();
    chk("lat_n_we", 64'(rf_we), 0);
    step();
    chk("lat_n1_we", 64'(rf_we), 0);
    step();
    chk("lat_n2_we", 64'(rf_we), 1);
    chk("lat_n2_addr", 64'(rf_waddr), 5);
    chk("lat_n2_data", 64'(rf_wdata), 64'h1234);
    drain(3);

    // Upper-lane word select.
    drive(1, 5'd3, 1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 0);
    expect_wr(3, 32'hAAAA_BBBB);
    step();
    drive(1, 5'd3, 0, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 0);
    expect_wr(3, 32'hCCCC_DDDD);
    step();
    idle();
    drain(5);

    // Dual retire: r1 then r2 on consecutive cycles.
    drive(1, 5'd1, 0, 64'h0000_0000_1111_1111, 1, 5'd2, 32'h2222_2222);
    expect_wr(1, 32'h1111_1111);
    expect_wr(2, 32'h2222_2222);
    step();
    idle();
    step(); step();
    chk("dual_first", 64'(rf_waddr), 1);
    step();
    chk("dual_second_we", 64'(rf_we), 1);
    chk("dual_second", 64'(rf_waddr), 2);
    drain(3);

    // Same destination: only the lower value lands.
    drive(1, 5'd7, 0, 64'h0000_0000_5555_5555, 1, 5'd7, 32'h7777_7777);
    expect_wr(7, 32'h7777_7777);
    step();
    idle();
    drain(5);

    // r0 is never written; an interlocked bundle is not accepted.
    drive(0, 0, 0, 0, 1, 5'd0, 32'hDEAD_0000);
    step();
    r_il_drv = 1'b1;
    drive(1, 5'd8, 0, 64'h1, 1, 5'd9, 32'hDEAD_0009);
    step();
    r_il_drv = 1'b0;
    idle();
    drain(5);

    // Back-pressure with interlock tied to wb_stall.
    r_tie = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'(10 + 2 * k), 0, {32'h0, 32'h100 + 32'(k)}, 1, 5'(11 + 2 * k), 32'h200 + 32'(k));
      expect_wr(5'(10 + 2 * k), 32'h100 + 32'(k));
      expect_wr(5'(11 + 2 * k), 32'h200 + 32'(k));
      ok = 1'b0;
      for (int w = 0; w < 20; w++) begin
        @(negedge clk);
        if (!wb_stall) begin
          ok = 1'b1;
          break;
        end
      end
      chk("bp_accept_in_time", 64'(ok), 1);
      step();
      idle();
      if (k == 0) chk("bp_stall_after1", 64'(wb_stall), 0);
      if (k == 1) chk("bp_stall_after2", 64'(wb_stall), 1);
    end
    drain(10);
    r_tie = 1'b0;

    // Forwarding: youngest r4 wins across queue, staging and rf stages.
    drive(0, 0, 0, 0, 1, 5'd4, 32'h10);
    expect_wr(4, 32'h10);
    step();
    drive(0, 0, 0, 0, 1, 5'd4, 32'h20);
    expect_wr(4, 32'h20);
    step();
    idle();
    fwd_addr = 5'd4; #1;
    chk("fwd_q_hit", 64'(fwd_hit), 1);
    chk("fwd_q_data", 64'(fwd_data), 64'h20);
    fwd_addr = 5'd0; #1;
    chk("fwd_r0_hit", 64'(fwd_hit), 0);
    chk("fwd_r0_data", 64'(fwd_data), 0);
    fwd_addr = 5'd9; #1;
    chk("fwd_miss_hit", 64'(fwd_hit), 0);
    chk("fwd_miss_data", 64'(fwd_data), 0);
    fwd_addr = 5'd4;
    step();
    chk("fwd_stage_data", 64'(fwd_data), 64'h20);
    step();
    chk("fwd_rf_hit", 64'(fwd_hit), 1);
    chk("fwd_rf_data", 64'(fwd_data), 64'h20);
    step();
    chk("fwd_done_hit", 64'(fwd_hit), 0);
    drain(3);

    // Reset mid-drain with three entries queued.
    drive(1, 5'd20, 0, 64'h20, 1, 5'd21, 32'h21);
    step();
    drive(1, 5'd22, 0, 64'h22, 1, 5'd23, 32'h23);
    step();
    idle();
    chk("pre_rst_stall", 64'(wb_stall), 1);
    rst = 1'b1;
    sbq.delete();
    #1;
    chk("mid_rst_we", 64'(rf_we), 0);
    chk("mid_rst_stall", 64'(wb_stall), 0);
`ifdef WB_RETIRE_COUNT_EN
    chk("mid_rst_retired", retired, 0);
`endif
    step();
    rst = 1'b0;
    fwd_addr = 5'd21;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_we", 64'(rf_we), 0);
    end
    chk("post_rst_fwd", 64'(fwd_hit), 0);

    chk("sb_empty", 64'(sbq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
